// File: rtl/fb_scanout.sv
// fb_scanout: VGA-style scanout of a 2x-scaled, centred framebuffer image.
// Generates line/frame timing, issues framebuffer reads over rx/ry, realigns
// the sync/enable/window flags with the returned rc data, and owns the
// tear-free buffer swap point at the start of vertical blanking.
//
// Ports:
//   clk            pixel clock
//   rst            synchronous active-high reset
//   rx, ry         framebuffer read column/row (registered)
//   rc             framebuffer read data, READ_LATENCY clocks after the address
//   swap_req       level-sensitive swap request from the renderer
//   swap_ack       one-cycle pulse: swap taken
//   switch_buffers one-cycle pulse to the framebuffer bank toggle
//   frame_start    one-cycle pulse for counter position (0,0)
//   hsync, vsync   active-low syncs
//   de             data enable (visible area)
//   rgb            pixel colour {R4,G4,B4}
module fb_scanout #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned FB_W         = 256,
  parameter int unsigned FB_H         = 128,
  parameter int unsigned SCALE_SHIFT  = 1,
  parameter int unsigned X_OFS        = 64,
  parameter int unsigned Y_OFS        = 112,
  parameter int unsigned READ_LATENCY = 4,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  rx,
  output logic [7:0]  ry,
  input  logic [11:0] rc,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        switch_buffers,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned X_END   = X_OFS + (FB_W << SCALE_SHIFT);
  localparam int unsigned Y_END   = Y_OFS + (FB_H << SCALE_SHIFT);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  // Flag bit positions inside one alignment-pipeline stage.
  localparam int unsigned ST_HS  = 3;
  localparam int unsigned ST_VS  = 2;
  localparam int unsigned ST_ACT = 1;
  localparam int unsigned ST_WIN = 0;
  // Inactive stage value: syncs deasserted (high), not active, not in window.
  localparam logic [3:0] ST_IDLE = 4'b1100;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   h32, v32;
  logic          act, win, hs, vs;
  logic [7:0]    rx_q, rx_d, ry_q, ry_d;
  logic [3:0]    pipe_q [READ_LATENCY];
  logic [3:0]    stage_d, tail;
  logic          swap_q, swap_d;
  logic          frame_start_q, frame_start_d;
  logic          hsync_q, vsync_q, de_q;
  logic [11:0]   rgb_q, rgb_d;

  // Line and frame counters.
  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      if (vcnt_q == VW'(V_TOTAL - 1)) vcnt_d = '0;
      else                            vcnt_d = vcnt_q + VW'(1);
    end
  end

  // Fetch stage: visibility, window test and framebuffer address.
  always_comb begin
    h32  = 32'(hcnt_q);
    v32  = 32'(vcnt_q);
    act  = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    win  = act && (h32 >= X_OFS) && (h32 < X_END) && (v32 >= Y_OFS) && (v32 < Y_END);
    hs   = !((h32 >= HS_BEG) && (h32 < HS_END));
    vs   = !((v32 >= VS_BEG) && (v32 < VS_END));
    rx_d = '0;
    ry_d = '0;
    if (win) begin
      rx_d = 8'((h32 - X_OFS) >> SCALE_SHIFT);
      ry_d = 8'((v32 - Y_OFS) >> SCALE_SHIFT);
    end
    stage_d = {hs, vs, act, win};
  end

  // Swap point and frame marker come straight from the counters.
  always_comb begin
    swap_d        = (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE)) && swap_req;
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // Output colour from the flags that arrive together with rc.
  always_comb begin
    tail = pipe_q[READ_LATENCY-1];
    if (tail[ST_WIN])      rgb_d = rc;
    else if (tail[ST_ACT]) rgb_d = BORDER_COLOR;
    else                   rgb_d = 12'h000;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      swap_q        <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= ST_IDLE;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      swap_q        <= swap_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= tail[ST_HS];
      vsync_q       <= tail[ST_VS];
      de_q          <= tail[ST_ACT];
      rgb_q         <= rgb_d;
      pipe_q[0]     <= stage_d;
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rx             = rx_q;
  assign ry             = ry_q;
  assign swap_ack       = swap_q;
  assign switch_buffers = swap_q;
  assign frame_start    = frame_start_q;
  assign hsync          = hsync_q;
  assign vsync          = vsync_q;
  assign de             = de_q;
  assign rgb            = rgb_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced raster (56x37 clocks per frame) so that
// several whole frames fit in a short run. A cycle-indexed reference model
// derives every output from the raster position; directed checks pin the
// model with hand-computed values.
module tb_fb_scanout;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;   // 56
  localparam int VT = VA + VFP + VSY + VBP;   // 37
  localparam int FRAME = HT * VT;             // 2072
  localparam int FW = 16, FH = 8, SS = 1, XO = 4, YO = 7, RL = 4;
  localparam logic [11:0] BC = 12'h5A5;

  logic        clk, rst, swap_req;
  logic [7:0]  rx, ry;
  logic [11:0] rc;
  logic        swap_ack, switch_buffers, frame_start, hsync, vsync, de;
  logic [11:0] rgb;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FB_W(FW), .FB_H(FH), .SCALE_SHIFT(SS), .X_OFS(XO), .Y_OFS(YO),
    .READ_LATENCY(RL), .BORDER_COLOR(BC)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .ry(ry), .rc(rc),
    .swap_req(swap_req), .swap_ack(swap_ack), .switch_buffers(switch_buffers),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data for an address computed in cycle t is on rc in cycle t+4.
  logic [11:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    m1 <= {ry[3:0], rx};
    m2 <= m1;
    m3 <= m2;
  end
  assign rc = m3;

  // n = clock edges since reset was last sampled; req_s = swap_req at that edge.
  int   n = 0;
  logic req_s = 1'b0;
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
    req_s <= swap_req;
  end

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  function automatic logic in_win(int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < HA) && (v < VA) && (h >= XO) && (h < XO + (FW << SS)) &&
           (v >= YO) && (v < YO + (FH << SS));
  endfunction

  function automatic logic [7:0] xaddr(int p);
    if (!in_win(p)) return 8'h00;
    return 8'(((p % HT) - XO) >> SS);
  endfunction

  function automatic logic [7:0] yaddr(int p);
    if (!in_win(p)) return 8'h00;
    return 8'((((p / HT) % VT) - YO) >> SS);
  endfunction

  // Expected {rx, ry, frame_start, swap_ack, switch_buffers, hsync, vsync, de, rgb}.
  function automatic logic [33:0] expect_at(int nn, logic req);
    logic [7:0]  ex, ey, qy;
    logic        fs, sw, hs, vs, den;
    logic [11:0] c;
    int          p, q, h, v;
    ex = 8'h00; ey = 8'h00; fs = 1'b0; sw = 1'b0;
    hs = 1'b1;  vs = 1'b1;  den = 1'b0; c = 12'h000;
    if (nn >= 1) begin
      p  = (nn - 1) % FRAME;
      ex = xaddr(p);
      ey = yaddr(p);
      fs = (p == 0);
      sw = (p == VA * HT) && req;
    end
    if (nn >= RL + 1) begin
      q   = (nn - RL - 1) % FRAME;
      h   = q % HT;
      v   = q / HT;
      hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
      vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      den = (h < HA) && (v < VA);
      if (in_win(q)) begin
        qy = yaddr(q);
        c  = {qy[3:0], xaddr(q)};
      end else if (den) begin
        c = BC;
      end
    end
    return {ex, ey, fs, sw, sw, hs, vs, den, c};
  endfunction

  // Per-cycle comparison against the model.
  logic [33:0] exp_v, got_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = expect_at(n, req_s);
      got_v = {rx, ry, frame_start, swap_ack, switch_buffers, hsync, vsync, de, rgb};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model n=%0d got=%h expected=%h", n, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic wait_n(input int t);
    int g;
    g = 0;
    while (n < t && g < 50000) begin
      @(negedge clk);
      g++;
    end
    chk("reach_cycle", n, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cnt, hs_low, vs_low, de_hi, first_hs, first_vs, pulses;
    rst = 1'b1;
    swap_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (700) @(negedge clk);

    // Reset in mid-frame.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_de", int'(de), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rx", int'(rx), 0);
    chk("rst_ry", int'(ry), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    rst = 1'b0;

    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("frame_start_after_release", cnt, 1);

    // Whole-frame timing statistics up to the next frame_start.
    cnt = 0; hs_low = 0; vs_low = 0; de_hi = 0; first_hs = -1; first_vs = -1;
    do begin
      @(negedge clk);
      cnt++;
      if (hsync === 1'b0) begin hs_low++; if (first_hs < 0) first_hs = cnt; end
      if (vsync === 1'b0) begin vs_low++; if (first_vs < 0) first_vs = cnt; end
      if (de === 1'b1) de_hi++;
    end while (frame_start !== 1'b1 && cnt < 5000);
    chk("frame_period", cnt, 2072);
    chk("hsync_low_clocks", hs_low, 222);
    chk("vsync_low_clocks", vs_low, 112);
    chk("de_high_clocks", de_hi, 1200);
    chk("first_hsync_low", first_hs, 48);
    chk("first_vsync_low", first_vs, 1796);

    // Address mapping and colour alignment in frame 1.
    wait_n(2072 + 397);
    chk("addr_first_rx", int'(rx), 0);
    chk("addr_first_ry", int'(ry), 0);
    wait_n(2072 + 399);
    chk("addr_second_rx", int'(rx), 1);
    wait_n(2072 + 511);
    chk("left_border_rgb", int'(rgb), 'h5A5);
    chk("left_border_de", int'(de), 1);
    wait_n(2072 + 513);
    chk("first_pixel_line9_rgb", int'(rgb), 'h100);
    wait_n(2072 + 546);
    chk("right_border_rgb", int'(rgb), 'h5A5);
    wait_n(2072 + 554);
    chk("blank_rgb", int'(rgb), 0);
    chk("blank_de", int'(de), 0);
    chk("blank_hsync", int'(hsync), 0);
    wait_n(2072 + 1268);
    chk("addr_last_rx", int'(rx), 15);
    chk("addr_last_ry", int'(ry), 7);
    wait_n(2072 + 1269);
    chk("addr_outside_rx", int'(rx), 0);
    chk("addr_outside_ry", int'(ry), 0);

    // Swap requested mid-frame, taken at the start of vblank.
    wait_n(2072 + 1400);
    swap_req = 1'b1;
    wait_n(3752);
    chk("swap_before_point", int'(swap_ack), 0);
    wait_n(3753);
    chk("swap_ack_pulse", int'(swap_ack), 1);
    chk("switch_pulse", int'(switch_buffers), 1);
    swap_req = 1'b0;
    wait_n(3754);
    chk("swap_after_point", int'(swap_ack), 0);

    // Request held across three frames.
    wait_n(3800);
    swap_req = 1'b1;
    pulses = 0;
    while (n < 3800 + 3 * FRAME) begin
      @(negedge clk);
      if (switch_buffers === 1'b1) pulses++;
    end
    chk("held_three_frames", pulses, 3);
    swap_req = 1'b0;

    // Request rising on the swap-point cycle itself.
    wait_n(5 * 2072 + 1680);
    swap_req = 1'b1;
    wait_n(5 * 2072 + 1681);
    chk("edge_same_cycle", int'(swap_ack), 1);
    swap_req = 1'b0;

    // Request rising one cycle late waits for the next frame.
    wait_n(6 * 2072 + 1681);
    swap_req = 1'b1;
    pulses = 0;
    while (n < 7 * 2072 + 1680) begin
      @(negedge clk);
      if (swap_ack === 1'b1) pulses++;
    end
    chk("edge_late_no_pulse", pulses, 0);
    wait_n(7 * 2072 + 1681);
    chk("edge_late_next_frame", int'(swap_ack), 1);
    swap_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Downstream consumer of the double-buffered framebuffer (256x128, RGB444).
- Generates 640x480 VGA-style timing and reads the framebuffer over its rx/ry/rc read port.
- Scales the image 2x and centres it; pixels outside the image window show a border colour.
- Owns the buffer-swap point: the renderer requests a swap, and the block pulses switch_buffers at vblank start so swaps never tear.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, hsync width, in clocks
- H_BP, 48, horizontal back porch, in clocks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- FB_W, 256, framebuffer width in pixels
- FB_H, 128, framebuffer height in pixels
- SCALE_SHIFT, 1, log2 of the pixel replication factor
- X_OFS, 64, first display column of the image window
- Y_OFS, 112, first display line of the image window
- READ_LATENCY, 4, clocks from rx/ry being driven to the matching rc being valid
- BORDER_COLOR, 12'h000, colour driven for active pixels outside the window

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, reset (synchronous, active-high)
- rx, out, 8, framebuffer read column
- ry, out, 8, framebuffer read row
- rc, in, 12, framebuffer read data, valid READ_LATENCY clocks after rx/ry
- swap_req, in, 1, level-sensitive swap request from the renderer
- swap_ack, out, 1, one-cycle pulse: swap taken
- switch_buffers, out, 1, one-cycle pulse to the framebuffer bank toggle
- frame_start, out, 1, one-cycle pulse at hcnt=0, vcnt=0
- hsync, out, 1, active-low horizontal sync
- vsync, out, 1, active-low vertical sync
- de, out, 1, data enable (visible area)
- rgb, out, 12, pixel colour {R4,G4,B4}

Behaviour:

Reset:
- hcnt=vcnt=0; rx=ry=0; rgb=0; de=0; hsync=vsync=1; swap_ack=switch_buffers=frame_start=0.
- All delay-pipeline stages are cleared to these inactive values.
- Reset mid-line or mid-frame restarts timing at (0,0) on the next clock.

Counters:
- H_TOTAL = 800 and V_TOTAL = 525 (sum of the respective parameters).
- hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt increments when hcnt wraps, and wraps to 0 after V_TOTAL-1.

Fetch stage (combinational from the counters, registered into rx/ry):
- act = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- win = act && X_OFS <= hcnt < X_OFS + (FB_W << SCALE_SHIFT) && Y_OFS <= vcnt < Y_OFS + (FB_H << SCALE_SHIFT).
- If win: rx = (hcnt - X_OFS) >> SCALE_SHIFT and ry = (vcnt - Y_OFS) >> SCALE_SHIFT, truncated to 8 bits.
- Otherwise rx = ry = 0.
- hs = !(H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC). vs is the same with V terms.

Alignment pipeline:
- {hs, vs, act, win} pass through READ_LATENCY register stages, aligned with rc.
- The output register then drives:
  - hsync = hs_d, vsync = vs_d, de = act_d.
  - rgb = win_d ? rc : (act_d ? BORDER_COLOR : 0).
- Total output latency from a counter position is READ_LATENCY+1 clocks, identical for all outputs.
- frame_start is not delayed.

Swap handshake:
- The swap point is the cycle with hcnt=0, vcnt=V_ACTIVE (start of vblank).
- At the swap point with swap_req=1, switch_buffers and swap_ack are both 1 for that one cycle.
- Otherwise both are 0.
- swap_req is sampled only at the swap point, so at most one swap occurs per frame.
- swap_req held high across frames produces one swap per frame. The renderer must drop swap_req after swap_ack.
- swap_req rising on the swap-point cycle itself is taken.
- Reset on the swap-point cycle: no pulse.

Test Plan:
1. Reset: hold rst for 3 clocks mid-frame → rgb=0, de=0, hsync=vsync=1, rx=ry=0. After release, frame_start is asserted exactly 1 clock later and 420000 clocks after that.
2. Line and frame timing: count over a full frame → hsync low for 96 clocks per 800-clock line, starting 656+5 clocks after line start. vsync low for 2 lines (1600 clocks) starting at line 490. de high for 640 clocks on each of 480 lines.
3. Address mapping: at hcnt=64,vcnt=112 → rx=0,ry=0. At hcnt=66 → rx=1. At hcnt=575,vcnt=367 → rx=255,ry=127. At hcnt=576 → rx=0 (outside window).
4. Colour alignment: latency-4 memory model returns rc={ry[3:0],rx[7:0]} → first window pixel of line 114 shows rgb=12'h100, 5 clocks after hcnt=64. Border pixels show rgb=12'h000 while de=1. Blanking shows rgb=0.
5. Swap handshake: swap_req raised at line 200 → switch_buffers and swap_ack pulse once at hcnt=0,vcnt=480. With swap_req held high for 3 frames → exactly 3 pulses.
6. Edge swap: swap_req asserted exactly on the swap-point cycle → pulse that cycle. swap_req asserted one cycle after → no pulse until the next frame's swap point.
